// File: rtl/rv_pkg.sv
// RV32I opcode constants, immediate formats and the decode bundle
// shared by the decode stage and its immediate generator.
package rv_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_t;

  typedef struct packed {
    logic     useA;
    logic     useB;
    logic     wrRd;
    logic     illegal;
    imm_fmt_t fmt;
  } dec_t;

  function automatic dec_t mkDec(
    logic     a,
    logic     b,
    logic     w,
    imm_fmt_t f
  );
    dec_t d;
    d.useA    = a;
    d.useB    = b;
    d.wrRd    = w;
    d.illegal = 1'b0;
    d.fmt     = f;
    return d;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate former: picks and sign-extends the immediate
// field of an instruction word according to its format.
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    unique case (fmt)
      FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm = {{20{instr[31]}}, instr[31:25],
                    instr[11:7]};
      FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm = {instr[31:12], 12'b0};
      FMT_J: imm = {{11{instr[31]}}, instr[31],
                    instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_scoreboard.sv
// RV32I decode stage with a per-register busy scoreboard.
// Define DECODE_WB_BYPASS_EN to let a retiring register unblock issue.
module decode_scoreboard
  import rv_pkg::*;
#(
  parameter int dataWidth    = 32,
  parameter int AddressWidth = 5
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [dataWidth-1:0]    in_instr,
  input  logic [dataWidth-1:0]    in_pc,
  input  logic                    flush,
  output logic [AddressWidth-1:0] RegA,
  output logic [AddressWidth-1:0] RegB,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [dataWidth-1:0]    out_pc,
  output logic [dataWidth-1:0]    out_imm,
  output logic [6:0]              out_opcode,
  output logic [2:0]              out_funct3,
  output logic [6:0]              out_funct7,
  output logic [AddressWidth-1:0] out_rd,
  output logic                    out_rd_we,
  output logic                    out_illegal,
  input  logic                    wb_valid,
  input  logic [AddressWidth-1:0] wb_rd
);

  localparam int NumRegs = 2 ** AddressWidth;

  logic                    heldValid;
  logic [dataWidth-1:0]    heldInstr;
  logic [dataWidth-1:0]    heldPc;
  logic [NumRegs-1:0]      busy;
  logic [NumRegs-1:0]      busyEff;
  logic [NumRegs-1:0]      busyNext;
  logic [6:0]              opc;
  logic [AddressWidth-1:0] rs1;
  logic [AddressWidth-1:0] rs2;
  logic [AddressWidth-1:0] rd;
  dec_t                    dec;
  logic                    rdWe;
  logic                    hazard;
  logic                    fire;
  logic                    accept;

  assign opc = heldInstr[6:0];
  assign rd  = heldInstr[7 +: AddressWidth];
  assign rs1 = heldInstr[15 +: AddressWidth];
  assign rs2 = heldInstr[20 +: AddressWidth];

  always_comb begin
    dec         = '0;
    dec.illegal = 1'b1;
    unique case (1'b1)
      (opc == OP):     dec = mkDec(1'b1, 1'b1, 1'b1, FMT_R);
      (opc == OP_IMM): dec = mkDec(1'b1, 1'b0, 1'b1, FMT_I);
      (opc == LOAD):   dec = mkDec(1'b1, 1'b0, 1'b1, FMT_I);
      (opc == STORE):  dec = mkDec(1'b1, 1'b1, 1'b0, FMT_S);
      (opc == BRANCH): dec = mkDec(1'b1, 1'b1, 1'b0, FMT_B);
      (opc == JAL):    dec = mkDec(1'b0, 1'b0, 1'b1, FMT_J);
      (opc == JALR):   dec = mkDec(1'b1, 1'b0, 1'b1, FMT_I);
      (opc == LUI):    dec = mkDec(1'b0, 1'b0, 1'b1, FMT_U);
      (opc == AUIPC):  dec = mkDec(1'b0, 1'b0, 1'b1, FMT_U);
      default: ;
    endcase
  end

  assign rdWe = dec.wrRd & (rd != '0);

  // Bypass view: a register retiring this cycle no longer blocks.
  always_comb begin
    busyEff = busy;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_valid) busyEff[wb_rd] = 1'b0;
`endif
  end

  assign hazard = (dec.useA & busyEff[rs1])
                | (dec.useB & busyEff[rs2])
                | (rdWe & busyEff[rd]);

  assign out_valid = heldValid & ~hazard & ~flush;
  assign fire      = out_valid & out_ready;
  assign in_ready  = ~heldValid | fire;
  assign accept    = in_valid & in_ready & ~flush;

  always_ff @(posedge Clk) begin
    if (reset) begin
      heldValid <= 1'b0;
      heldInstr <= '0;
      heldPc    <= '0;
    end else if (flush) begin
      heldValid <= 1'b0;
    end else if (accept) begin
      heldValid <= 1'b1;
      heldInstr <= in_instr;
      heldPc    <= in_pc;
    end else if (fire) begin
      heldValid <= 1'b0;
    end
  end

  // Set after clear so a same-edge issue to a retiring index wins.
  always_comb begin
    busyNext = busy;
    if (wb_valid) busyNext[wb_rd] = 1'b0;
    if (fire && rdWe) busyNext[rd] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (reset) busy <= '0;
    else       busy <= busyNext;
  end

  assign RegA        = dec.useA ? rs1 : '0;
  assign RegB        = dec.useB ? rs2 : '0;
  assign out_pc      = heldPc;
  assign out_opcode  = opc;
  assign out_funct3  = heldInstr[14:12];
  assign out_funct7  = heldInstr[31:25];
  assign out_rd      = rd;
  assign out_rd_we   = rdWe;
  assign out_illegal = heldValid & dec.illegal;

  imm_gen uImm (
    .instr(heldInstr[31:7]),
    .fmt  (dec.fmt),
    .imm  (out_imm)
  );

endmodule

// File: tb/tb_decode_scoreboard.sv
// Scoreboard bench for decode_scoreboard: directed cases plus
// randomized traffic against a behavioural decode/busy model.
module tb_decode_scoreboard;

  logic        Clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic [4:0]  RegA;
  logic [4:0]  RegB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;

  always #5 Clk = ~Clk;

  decode_scoreboard dut (
    .Clk(Clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .RegA(RegA), .RegB(RegB),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm),
    .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

`ifdef DECODE_WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] ADD  = 32'h00108133;
  localparam logic [31:0] SW   = 32'h0020A423;
  localparam logic [31:0] BEQ  = 32'hFE000EE3;
  localparam logic [31:0] LUI5 = 32'h123452B7;
  localparam logic [31:0] ADD6 = 32'h00528333;
  localparam logic [31:0] ILL  = 32'h0000017F;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    int          rs1;
    int          rs2;
    int          rd;
    bit          useA;
    bit          useB;
    bit          wr;
    bit          ill;
  } exp_t;

  exp_t heldQ[$];
  bit   busyM[32];
  bit   expInReady = 1'b1;
  bit   accepted;
  int   checks = 0;
  int   errors = 0;
  int   issued = 0;

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic int sext(int x, int n);
    return (x >= (1 << (n - 1))) ? x - (1 << n) : x;
  endfunction

  // Reference decode straight from the RV32I field definitions.
  function automatic exp_t model(logic [31:0] w,
                                 logic [31:0] pc);
    exp_t e;
    int   v;
    e.instr = w;
    e.pc    = pc;
    e.rd    = int'(w[11:7]);
    e.rs1   = int'(w[19:15]);
    e.rs2   = int'(w[24:20]);
    e.useA  = 0;
    e.useB  = 0;
    e.wr    = 0;
    e.ill   = 0;
    v       = 0;
    case (w[6:0])
      7'h33: begin e.useA = 1; e.useB = 1; e.wr = 1; end
      7'h13, 7'h03, 7'h67: begin
        e.useA = 1; e.wr = 1;
        v = sext(int'(w[31:20]), 12);
      end
      7'h23: begin
        e.useA = 1; e.useB = 1;
        v = sext(int'({w[31:25], w[11:7]}), 12);
      end
      7'h63: begin
        e.useA = 1; e.useB = 1;
        v = sext(int'({w[31], w[7], w[30:25],
                       w[11:8], 1'b0}), 13);
      end
      7'h6F: begin
        e.wr = 1;
        v = sext(int'({w[31], w[19:12], w[20],
                       w[30:21], 1'b0}), 21);
      end
      7'h37, 7'h17: begin
        e.wr = 1;
        v = int'(w[31:12]) * 4096;
      end
      default: e.ill = 1;
    endcase
    if (e.rd == 0) e.wr = 0;
    e.imm = v;
    return e;
  endfunction

  task automatic monitorStep();
    exp_t e;
    bit   have;
    bit   hz;
    bit   eov;
    bit   efire;
    bit   b[32];
    if (reset) begin
      heldQ.delete();
      foreach (busyM[i]) busyM[i] = 0;
      expInReady = 1;
      return;
    end
    have = heldQ.size() > 0;
    b    = busyM;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_valid) b[wb_rd] = 0;
`endif
    hz = 0;
    if (have) begin
      e  = heldQ[0];
      hz = (e.useA && b[e.rs1]) || (e.useB && b[e.rs2])
        || (e.wr && b[e.rd]);
    end
    eov        = have && !hz && !flush;
    efire      = eov && out_ready;
    expInReady = !have || efire;
    chk("out_valid", out_valid, eov);
    chk("in_ready", in_ready, expInReady);
    if (have) begin
      chk("RegA", RegA, e.useA ? e.rs1 : 0);
      chk("RegB", RegB, e.useB ? e.rs2 : 0);
      chk("out_pc", out_pc, e.pc);
      chk("out_imm", out_imm, e.imm);
      chk("out_opcode", out_opcode, e.instr[6:0]);
      chk("out_funct3", out_funct3, e.instr[14:12]);
      chk("out_funct7", out_funct7, e.instr[31:25]);
      chk("out_rd", out_rd, e.rd);
      chk("out_rd_we", out_rd_we, e.wr);
      chk("out_illegal", out_illegal, e.ill);
    end
    if (efire) begin
      void'(heldQ.pop_front());
      issued++;
    end
    if (flush) heldQ.delete();
    if (wb_valid) busyM[wb_rd] = 0;
    if (efire && e.wr) busyM[e.rd] = 1;
    busyM[0] = 0;
  endtask

  always @(negedge Clk) monitorStep();

  task automatic tick();
    @(negedge Clk);
    #1;
    accepted = in_valid && expInReady && !flush && !reset;
    if (accepted) heldQ.push_back(model(in_instr, in_pc));
    @(posedge Clk);
    #1;
  endtask

  task automatic offer(logic [31:0] w, logic [31:0] pc);
    in_valid = 1;
    in_instr = w;
    in_pc    = pc;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (accepted) break;
    end
    chk("offer accepted", accepted, 1);
    in_valid = 0;
  endtask

  task automatic releaseAll();
    in_valid  = 0;
    out_ready = 1;
    for (int p = 0; p < 3; p++) begin
      for (int r = 1; r < 32; r++) begin
        if (busyM[r]) begin
          wb_valid = 1;
          wb_rd    = 5'(r);
          tick();
        end
      end
      wb_valid = 0;
      tick();
      tick();
    end
  endtask

  function automatic logic [31:0] randInstr();
    logic [6:0]  ops[10];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
            7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    w        = $urandom();
    w[6:0]   = ops[$urandom_range(9)];
    w[11:7]  = 5'($urandom_range(3));
    w[19:15] = 5'($urandom_range(3));
    w[24:20] = 5'($urandom_range(3));
    return w;
  endfunction

  initial begin
    int cand[$];
    reset     = 1;
    in_valid  = 0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 0;
    out_ready = 0;
    wb_valid  = 0;
    wb_rd     = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset RegA", RegA, 0);
    chk("reset RegB", RegB, 0);
    chk("reset out_imm", out_imm, 0);
    chk("reset out_pc", out_pc, 0);
    chk("reset out_rd_we", out_rd_we, 0);
    chk("reset out_illegal", out_illegal, 0);
    reset = 0;
    @(posedge Clk);
    #1;

    // addi then dependent add
    out_ready = 1;
    offer(ADDI, 32'h100);
    in_valid = 1; in_instr = ADD; in_pc = 32'h104;
    #1;
    chk("addi imm", out_imm, 5);
    chk("addi rd", out_rd, 1);
    chk("addi valid", out_valid, 1);
    tick();
    in_valid = 0;
    #1;
    chk("add stall", out_valid, 0);
    chk("add RegA", RegA, 1);
    chk("add RegB", RegB, 1);
    tick();
    tick();
    wb_valid = 1; wb_rd = 5'd1;
    #1;
    chk("add wb cycle", out_valid, Byp);
    tick();
    wb_valid = 0;
    #1;
    chk("add after wb", out_valid, !Byp);
    tick();

    // store and branch immediates
    wb_valid = 1; wb_rd = 5'd2;
    in_valid = 1; in_instr = SW; in_pc = 32'h108;
    tick();
    wb_valid = 0; in_instr = BEQ; in_pc = 32'h10C;
    #1;
    chk("sw rd_we", out_rd_we, 0);
    chk("sw imm", out_imm, 8);
    chk("sw RegA", RegA, 1);
    chk("sw RegB", RegB, 2);
    tick();
    in_valid = 0;
    #1;
    chk("beq imm", out_imm, 32'hFFFFFFFC);
    tick();

    // flush of a stalled add drops the new input
    offer(ADDI, 32'h110);
    in_valid = 1; in_instr = ADD; in_pc = 32'h114;
    tick();
    in_valid = 0;
    #1;
    chk("pre-flush stall", out_valid, 0);
    flush = 1; in_valid = 1; in_instr = LUI5; in_pc = 32'h118;
    #1;
    chk("flush out_valid", out_valid, 0);
    tick();
    flush = 0; in_valid = 0;
    #1;
    chk("flush dropped", out_valid, 0);
    chk("flush in_ready", in_ready, 1);
    offer(ADD, 32'h11C);
    #1;
    chk("busy kept", out_valid, 0);
    releaseAll();

    // backpressure hold
    out_ready = 0;
    offer(LUI5, 32'h200);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lui hold valid", out_valid, 1);
      chk("lui hold in_ready", in_ready, 0);
      chk("lui imm", out_imm, 32'h12345000);
      chk("lui rd", out_rd, 5);
      tick();
    end
    out_ready = 1;
    #1;
    chk("lui issue", out_valid, 1);
    tick();
    offer(ADD6, 32'h204);
    #1;
    chk("x5 busy", out_valid, 0);
    chk("x5 RegA", RegA, 5);
    releaseAll();

    // illegal opcode
    offer(ILL, 32'h300);
    #1;
    chk("ill flag", out_illegal, 1);
    chk("ill rd_we", out_rd_we, 0);
    chk("ill valid", out_valid, 1);
    chk("ill RegA", RegA, 0);
    tick();
    #1;
    chk("ill issued", out_valid, 0);

    // randomized traffic
    issued = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_instr  = randInstr();
      in_pc     = $urandom() & 32'hFFFF_FFFC;
      flush     = ($urandom_range(15) == 0);
      out_ready = ($urandom_range(3) != 0);
      cand.delete();
      for (int r = 1; r < 32; r++)
        if (busyM[r]) cand.push_back(r);
      if (cand.size() > 0 && $urandom_range(1) == 1) begin
        wb_valid = 1;
        wb_rd    = 5'(cand[$urandom_range(cand.size() - 1)]);
      end else begin
        wb_valid = ($urandom_range(7) == 0);
        wb_rd    = 5'($urandom_range(3));
      end
      tick();
    end
    flush    = 0;
    in_valid = 0;
    wb_valid = 0;
    chk("random progress", issued > 300, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
